uart_tx_arbiter: RTL

Shares a single uart_tx transmitter among NREQ byte-producing requesters, using round-robin arbitration. Each byte transfer is sequenced as grant, start pulse, wait for the transmitter's completion pulse, then a one-cycle guard gap. The block sits between the requester blocks and uart_tx; it drives uart_tx's start and data inputs and consumes its done pulse. An optional watchdog recovers from a transmitter that never completes.

---
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte requesters.
// Optional WAIT-state watchdog compiled in with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter  int NREQ        = 4,
    parameter  int TIMEOUT_CYC = 200000,
    localparam int OW          = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic [OW-1:0]     owner,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GAP
    } state_e;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_e            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [OW-1:0]     sel;
    int                idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
`endif

    // First requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = OW'(idx);
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        tx_data_d  = tx_data_q;
        ack_d      = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d    = sel;
                    tx_data_d  = req_data[8*sel +: 8];
                    tx_start_d = 1'b1;
                    ack_d      = ONE_HOT0 << sel;
                    ptr_d      = (sel == OW'(NREQ-1)) ? '0 : sel + OW'(1);
                    state_d    = S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end

            S_WAIT: begin
                // A completion coinciding with our own start pulse is stale.
                if (tx_done && !tx_start_q) begin
                    done_d  = ONE_HOT0 << owner_q;
                    state_d = S_GAP;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC-1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end

            S_GAP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign ack      = ack_q;
    assign done     = done_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule
